// File: rtl/vend_pkg.sv
// Shared types and coin helpers for the multi-item vending sequencer.
package vend_pkg;

    localparam logic [1:0] COIN_0   = 2'b00;
    localparam logic [1:0] COIN_5   = 2'b01;
    localparam logic [1:0] COIN_10  = 2'b10;
    localparam logic [1:0] COIN_BAD = 2'b11;

    typedef enum logic [1:0] {StIdle, StCollect, StVend, StChange} state_e;

    // Value of a coin code in 5-rupee units; invalid and empty codes are worth nothing.
    function automatic logic [1:0] coin_value(input logic [1:0] c);
        case (c)
            COIN_5:  coin_value = 2'd1;
            COIN_10: coin_value = 2'd2;
            default: coin_value = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_item_table.sv
// Per-item price and stock storage: one config write port, one decrement port, async read.
module vend_item_table
    import vend_pkg::*;
#(
    parameter int unsigned NUM_ITEMS = 4,
    parameter int unsigned CREDIT_W  = 6,
    parameter int unsigned STOCK_W   = 4,
    parameter int unsigned IDX_W     = $clog2(NUM_ITEMS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_item,
    input  logic [CREDIT_W-1:0] wr_price,
    input  logic [STOCK_W-1:0]  wr_stock,
    input  logic                dec_en,
    input  logic [IDX_W-1:0]    dec_item,
    input  logic [IDX_W-1:0]    rd_item,
    output logic [CREDIT_W-1:0] rd_price,
    output logic [STOCK_W-1:0]  rd_stock
);

    logic [CREDIT_W-1:0] price_q [NUM_ITEMS];
    logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                price_q[i] <= '0;
                stock_q[i] <= '0;
            end
        end else if (wr_en) begin
            price_q[wr_item] <= wr_price;
            stock_q[wr_item] <= wr_stock;
        end else if (dec_en && stock_q[dec_item] != '0) begin
            stock_q[dec_item] <= stock_q[dec_item] - 1'b1;
        end
    end

    assign rd_price = price_q[rd_item];
    assign rd_stock = stock_q[rd_item];

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: credit accumulation, item selection, dispense and coin-by-coin change.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned NUM_ITEMS = 4,
    parameter int unsigned CREDIT_W  = 6,
    parameter int unsigned STOCK_W   = 4,
    parameter int unsigned IDX_W     = $clog2(NUM_ITEMS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [IDX_W-1:0]    sel_item,
    input  logic                cancel,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_item,
    input  logic [CREDIT_W-1:0] cfg_price,
    input  logic [STOCK_W-1:0]  cfg_stock,
    output logic                vend_req,
    output logic [IDX_W-1:0]    vend_item,
    input  logic                vend_ack,
    output logic                chg_req,
    output logic [1:0]          chg_coin,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_e              state_q;
    logic                after_vend_q;
    logic [CREDIT_W-1:0] rd_price;
    logic [STOCK_W-1:0]  rd_stock;
    logic                accepting, coin_valid, sel_ok, buy, coin_take, err_d;
    logic [CREDIT_W-1:0] collect_base, new_credit, chg_next;
    logic [CREDIT_W:0]   coin_sum;

    vend_item_table #(
        .NUM_ITEMS (NUM_ITEMS),
        .CREDIT_W  (CREDIT_W),
        .STOCK_W   (STOCK_W),
        .IDX_W     (IDX_W)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (cfg_we && state_q == StIdle),
        .wr_item  (cfg_item),
        .wr_price (cfg_price),
        .wr_stock (cfg_stock),
        .dec_en   (buy),
        .dec_item (sel_item),
        .rd_item  (sel_item),
        .rd_price (rd_price),
        .rd_stock (rd_stock)
    );

    always_comb begin
        accepting    = (state_q == StIdle) || (state_q == StCollect);
        coin_valid   = (coin == COIN_5) || (coin == COIN_10);
        sel_ok       = sel_valid && rd_stock != '0 && rd_price != '0 && credit >= rd_price;
        buy          = (state_q == StCollect) && !cancel && sel_ok;
        collect_base = buy ? credit - rd_price : credit;
        // The same-cycle coin lands on top of whatever the selection left behind.
        coin_sum     = {1'b0, collect_base} + {{(CREDIT_W-1){1'b0}}, coin_value(coin)};
        coin_take    = accepting && coin_valid && !coin_sum[CREDIT_W];
        new_credit   = coin_take ? coin_sum[CREDIT_W-1:0] : collect_base;
        chg_next     = credit - {{(CREDIT_W-2){1'b0}}, coin_value(chg_coin)};
        err_d        = (coin == COIN_BAD)
                     || (accepting && coin_valid && coin_sum[CREDIT_W])
                     || (!accepting && coin_valid)
                     || (cfg_we && state_q != StIdle)
                     || (state_q == StIdle && (sel_valid || cancel))
                     || (state_q == StCollect && !cancel && sel_valid && !sel_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            after_vend_q <= 1'b0;
            credit       <= '0;
            vend_req     <= 1'b0;
            vend_item    <= '0;
            chg_req      <= 1'b0;
            chg_coin     <= COIN_0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= err_d;
            case (state_q)
                StIdle: begin
                    if (coin_take) begin
                        credit  <= new_credit;
                        state_q <= StCollect;
                    end
                end
                StCollect: begin
                    credit <= new_credit;
                    if (cancel) begin
                        state_q      <= StChange;
                        chg_req      <= 1'b1;
                        chg_coin     <= (new_credit >= CREDIT_W'(2)) ? COIN_10 : COIN_5;
                        busy         <= 1'b1;
                        after_vend_q <= 1'b0;
                    end else if (buy) begin
                        state_q   <= StVend;
                        vend_req  <= 1'b1;
                        vend_item <= sel_item;
                        busy      <= 1'b1;
                    end
                end
                StVend: begin
                    if (vend_ack && vend_req) begin
                        vend_req <= 1'b0;
                        if (credit == '0) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state_q      <= StChange;
                            chg_req      <= 1'b1;
                            chg_coin     <= (credit >= CREDIT_W'(2)) ? COIN_10 : COIN_5;
                            after_vend_q <= 1'b1;
                        end
                    end
                end
                StChange: begin
                    if (chg_ack && chg_req) begin
                        credit <= chg_next;
                        if (chg_next == '0) begin
                            state_q <= StIdle;
                            chg_req <= 1'b0;
                            busy    <= 1'b0;
                            done    <= after_vend_q;
                        end else begin
                            chg_coin <= (chg_next >= CREDIT_W'(2)) ? COIN_10 : COIN_5;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller with a queue scoreboard of dispensed items and coins.
module tb_vend_controller;
    import vend_pkg::*;

    localparam int NUM_ITEMS = 4;
    localparam int CREDIT_W  = 6;
    localparam int STOCK_W   = 4;
    localparam int IDX_W     = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [1:0]          coin = 2'b00;
    logic                sel_valid = 1'b0;
    logic [IDX_W-1:0]    sel_item = '0;
    logic                cancel = 1'b0;
    logic                cfg_we = 1'b0;
    logic [IDX_W-1:0]    cfg_item = '0;
    logic [CREDIT_W-1:0] cfg_price = '0;
    logic [STOCK_W-1:0]  cfg_stock = '0;
    logic                vend_req;
    logic [IDX_W-1:0]    vend_item;
    logic                vend_ack = 1'b0;
    logic                chg_req;
    logic [1:0]          chg_coin;
    logic                chg_ack = 1'b0;
    logic [CREDIT_W-1:0] credit;
    logic                busy, done, err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [IDX_W-1:0] vend_q [$];
    logic [1:0]       chg_q  [$];

    vend_controller #(
        .NUM_ITEMS (NUM_ITEMS),
        .CREDIT_W  (CREDIT_W),
        .STOCK_W   (STOCK_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .coin      (coin),
        .sel_valid (sel_valid),
        .sel_item  (sel_item),
        .cancel    (cancel),
        .cfg_we    (cfg_we),
        .cfg_item  (cfg_item),
        .cfg_price (cfg_price),
        .cfg_stock (cfg_stock),
        .vend_req  (vend_req),
        .vend_item (vend_item),
        .vend_ack  (vend_ack),
        .chg_req   (chg_req),
        .chg_coin  (chg_coin),
        .chg_ack   (chg_ack),
        .credit    (credit),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input int item, input int price, input int stock);
        cfg_we    = 1'b1;
        cfg_item  = IDX_W'(item);
        cfg_price = CREDIT_W'(price);
        cfg_stock = STOCK_W'(stock);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic put_coin(input logic [1:0] c);
        coin = c;
        tick();
        coin = 2'b00;
    endtask

    task automatic select(input int item);
        sel_valid = 1'b1;
        sel_item  = IDX_W'(item);
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic cancel_pulse();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    // Pops the scoreboard as the DUT presents each change coin, then acks it.
    task automatic drain_change(input logic exp_done, input string tag);
        logic [1:0] exp;
        int n = 0;
        while (chg_req === 1'b1 && n < 40) begin
            total_cnt++;
            if (chg_q.size() == 0) begin
                $display("FAIL %s_extra_coin: got coin %b, required no further coin", tag, chg_coin);
            end else begin
                exp = chg_q.pop_front();
                if (chg_coin !== exp)
                    $display("FAIL %s_chg_coin%0d: got %b, required %b", tag, n, chg_coin, exp);
                else pass_cnt++;
            end
            chg_ack = 1'b1;
            tick();
            chg_ack = 1'b0;
            n++;
        end
        total_cnt++;
        if (chg_req !== 1'b0) $display("FAIL %s_chg_timeout: chg_req %b, required 0", tag, chg_req);
        else pass_cnt++;
        total_cnt++;
        if (chg_q.size() != 0)
            $display("FAIL %s_chg_missing: %0d coins unpaid, required 0", tag, chg_q.size());
        else pass_cnt++;
        chg_q.delete();
        total_cnt++;
        if (done !== exp_done) $display("FAIL %s_done: got %b, required %b", tag, done, exp_done);
        else pass_cnt++;
        total_cnt++;
        if (credit !== 6'd0 || busy !== 1'b0)
            $display("FAIL %s_idle: credit %0d busy %b, required 0 0", tag, credit, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        total_cnt++;
        if ({credit, vend_req, vend_item, chg_req, chg_coin, busy, done, err} !== '0)
            $display("FAIL reset_outputs: got %b, required all zero",
                     {credit, vend_req, vend_item, chg_req, chg_coin, busy, done, err});
        else pass_cnt++;
    endtask

    task automatic test_exact();
        logic [IDX_W-1:0] exp;
        configure(2, 3, 1);
        put_coin(COIN_10);
        put_coin(COIN_5);
        total_cnt++;
        if (credit !== 6'd3) $display("FAIL exact_credit: got %0d, required 3", credit);
        else pass_cnt++;
        vend_q.push_back(2'd2);
        select(2);
        total_cnt++;
        if (vend_req !== 1'b1 || busy !== 1'b1 || credit !== 6'd0)
            $display("FAIL exact_vend: req %b busy %b credit %0d, required 1 1 0",
                     vend_req, busy, credit);
        else pass_cnt++;
        exp = vend_q.pop_front();
        total_cnt++;
        if (vend_item !== exp) $display("FAIL exact_item: got %0d, required %0d", vend_item, exp);
        else pass_cnt++;
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        total_cnt++;
        if (vend_req !== 1'b0 || done !== 1'b1 || chg_req !== 1'b0 || credit !== 6'd0)
            $display("FAIL exact_done: req %b done %b chg %b credit %0d, required 0 1 0 0",
                     vend_req, done, chg_req, credit);
        else pass_cnt++;
        // A stray ack with no request outstanding must change nothing.
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || vend_req !== 1'b0)
            $display("FAIL exact_stray_ack: done %b busy %b err %b req %b, required 0 0 0 0",
                     done, busy, err, vend_req);
        else pass_cnt++;
    endtask

    task automatic test_overpay();
        logic [IDX_W-1:0] exp;
        configure(2, 3, 2);
        put_coin(COIN_10);
        put_coin(COIN_10);
        vend_q.push_back(2'd2);
        select(2);
        exp = vend_q.pop_front();
        total_cnt++;
        if (vend_req !== 1'b1 || vend_item !== exp || credit !== 6'd1)
            $display("FAIL over_vend: req %b item %0d credit %0d, required 1 %0d 1",
                     vend_req, vend_item, credit, exp);
        else pass_cnt++;
        chg_q.push_back(COIN_5);
        vend_ack = 1'b1;
        tick();
        vend_ack = 1'b0;
        total_cnt++;
        if (vend_req !== 1'b0 || chg_req !== 1'b1 || done !== 1'b0)
            $display("FAIL over_to_change: vreq %b creq %b done %b, required 0 1 0",
                     vend_req, chg_req, done);
        else pass_cnt++;
        drain_change(1'b1, "over");
    endtask

    task automatic test_soldout_cancel();
        configure(2, 3, 0);
        put_coin(COIN_10);
        put_coin(COIN_10);
        select(2);
        total_cnt++;
        if (err !== 1'b1 || credit !== 6'd4 || vend_req !== 1'b0)
            $display("FAIL soldout_reject: err %b credit %0d req %b, required 1 4 0",
                     err, credit, vend_req);
        else pass_cnt++;
        chg_q.push_back(COIN_10);
        chg_q.push_back(COIN_10);
        cancel_pulse();
        total_cnt++;
        if (chg_req !== 1'b1 || busy !== 1'b1 || err !== 1'b0)
            $display("FAIL cancel_start: chg %b busy %b err %b, required 1 1 0", chg_req, busy, err);
        else pass_cnt++;
        put_coin(COIN_5);
        total_cnt++;
        if (err !== 1'b1 || credit !== 6'd4)
            $display("FAIL coin_in_change: err %b credit %0d, required 1 4", err, credit);
        else pass_cnt++;
        drain_change(1'b0, "cancel");
    endtask

    task automatic test_insufficient();
        configure(2, 3, 1);
        put_coin(COIN_10);
        select(2);
        total_cnt++;
        if (err !== 1'b1 || credit !== 6'd2 || vend_req !== 1'b0 || busy !== 1'b0)
            $display("FAIL short_reject: err %b credit %0d req %b busy %b, required 1 2 0 0",
                     err, credit, vend_req, busy);
        else pass_cnt++;
        put_coin(COIN_BAD);
        total_cnt++;
        if (err !== 1'b1 || credit !== 6'd2)
            $display("FAIL bad_coin: err %b credit %0d, required 1 2", err, credit);
        else pass_cnt++;
        // Still collecting, so a cancel starts a refund rather than erroring.
        chg_q.push_back(COIN_10);
        cancel_pulse();
        total_cnt++;
        if (chg_req !== 1'b1 || err !== 1'b0)
            $display("FAIL short_still_collect: chg %b err %b, required 1 0", chg_req, err);
        else pass_cnt++;
        drain_change(1'b0, "short");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 31; i++) put_coin(COIN_10);
        total_cnt++;
        if (credit !== 6'd62) $display("FAIL sat_fill: got %0d, required 62", credit);
        else pass_cnt++;
        put_coin(COIN_10);
        total_cnt++;
        if (err !== 1'b1 || credit !== 6'd62)
            $display("FAIL sat_reject: err %b credit %0d, required 1 62", err, credit);
        else pass_cnt++;
        put_coin(COIN_5);
        total_cnt++;
        if (err !== 1'b0 || credit !== 6'd63)
            $display("FAIL sat_top: err %b credit %0d, required 0 63", err, credit);
        else pass_cnt++;
        for (int i = 0; i < 31; i++) chg_q.push_back(COIN_10);
        chg_q.push_back(COIN_5);
        cancel_pulse();
        drain_change(1'b0, "sat");
    endtask

    task automatic test_reset_mid_vend();
        logic [IDX_W-1:0] exp;
        configure(2, 3, 1);
        put_coin(COIN_10);
        put_coin(COIN_5);
        vend_q.push_back(2'd2);
        select(2);
        exp = vend_q.pop_front();
        total_cnt++;
        if (vend_req !== 1'b1 || vend_item !== exp)
            $display("FAIL rst_vend: req %b item %0d, required 1 %0d", vend_req, vend_item, exp);
        else pass_cnt++;
        configure(0, 1, 1);
        total_cnt++;
        if (err !== 1'b1 || vend_req !== 1'b1)
            $display("FAIL cfg_in_vend: err %b req %b, required 1 1", err, vend_req);
        else pass_cnt++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total_cnt++;
        if ({credit, vend_req, vend_item, chg_req, chg_coin, busy, done, err} !== '0)
            $display("FAIL rst_abort: got %b, required all zero",
                     {credit, vend_req, vend_item, chg_req, chg_coin, busy, done, err});
        else pass_cnt++;
        put_coin(COIN_5);
        select(2);
        total_cnt++;
        if (err !== 1'b1 || vend_req !== 1'b0 || credit !== 6'd1)
            $display("FAIL rst_tables_cleared: err %b req %b credit %0d, required 1 0 1",
                     err, vend_req, credit);
        else pass_cnt++;
        chg_q.push_back(COIN_5);
        cancel_pulse();
        drain_change(1'b0, "rst");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        tick();
        test_reset();
        test_exact();
        test_overpay();
        test_soldout_cancel();
        test_insufficient();
        test_saturation();
        test_reset_mid_vend();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
